// File: rtl/board_io_arbiter.sv
// board_io_arbiter: shares SW/KEY/LEDR between two Avalon-style masters with round-robin arbitration
module board_io_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  SW,
  input  logic [3:0]  KEY,
  output logic [7:0]  LEDR,
  input  logic        req0_read,
  input  logic        req0_write,
  input  logic        req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic [31:0] req0_rdata,
  output logic        req0_waitrequest,
  input  logic        req1_read,
  input  logic        req1_write,
  input  logic        req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic [31:0] req1_rdata,
  output logic        req1_waitrequest
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, next_state;
  logic [7:0] sw_s1, sw_sync;
  logic [3:0] key_s1, key_sync, key_stable, key_event;
  logic [3:0][CW-1:0] cnt;
  logic [3:0] settle, press, clr;
  logic r0, r1, g0, g1, ptr;
  // Arbitration, debounce settle detection and event-clear mask
  always_comb begin
    r0 = req0_read | req0_write;
    r1 = req1_read | req1_write;
    g0 = state == GRANT0;
    g1 = state == GRANT1;
    next_state = state != IDLE ? IDLE : (r0 && (!r1 || !ptr)) ? GRANT0 : r1 ? GRANT1 : IDLE;
    clr = (g0 && req0_read && req0_addr) ? req0_rdata[3:0] :
          (g1 && req1_read && req1_addr) ? req1_rdata[3:0] : 4'b0;
    settle = '0;
    for (int i = 0; i < 4; i++) settle[i] = (key_sync[i] != key_stable[i]) && (cnt[i] == LAST);
    press = settle & key_stable;
  end
  // Pin synchronizers, KEY debounce and sticky press events (a set beats a clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_sync <= '0;
      key_s1 <= '1;
      key_sync <= '1;
      key_stable <= '1;
      cnt <= '0;
      key_event <= '0;
    end else begin
      sw_s1 <= SW;
      sw_sync <= sw_s1;
      key_s1 <= KEY;
      key_sync <= key_s1;
      for (int i = 0; i < 4; i++)
        cnt[i] <= (key_sync[i] == key_stable[i] || settle[i]) ? '0 : cnt[i] + CW'(1);
      key_stable <= (key_stable & ~settle) | (key_sync & settle);
      key_event <= (key_event & ~clr) | press;
    end
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  // Registered bus outputs, LED register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
      LEDR <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      req0_waitrequest <= 1'b1;
      req1_waitrequest <= 1'b1;
    end else begin
      ptr <= g0 ? 1'b1 : g1 ? 1'b0 : ptr;
      LEDR <= (g0 && req0_write) ? req0_wdata : (g1 && req1_write) ? req1_wdata : LEDR;
      if (next_state == GRANT0) req0_rdata <= req0_addr ? {28'b0, key_event} : {24'b0, sw_sync};
      if (next_state == GRANT1) req1_rdata <= req1_addr ? {28'b0, key_event} : {24'b0, sw_sync};
      req0_waitrequest <= next_state != GRANT0;
      req1_waitrequest <= next_state != GRANT1;
    end
  end
endmodule
